execute_stage: RTL and testbench

//  8-bit ALU/execute pipeline stage, directly upstream of Data_memory.
//  - Takes decoded operands and control from operand fetch; applies forwarding; computes the result.
//  - Registers result, store data, destination and memory controls; these drive the data-memory stage.
//  - Single-cycle ops have 1-cycle latency; MUL is an 8-cycle iterative shift-add that stalls upstream.

---
 rtl/exec_pkg.sv | 42 ++++
 rtl/seq_multiplier.sv | 45 ++++
 rtl/execute_stage.sv | 124 ++++++++++++
 tb/tb_execute_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared widths, opcodes, forwarding selects, FSM states and the
// registered output bundle of the execute stage.
package exec_pkg;
    localparam int DW = 8;
    localparam int RW_W = 5;
    localparam int MUL_CYC = DW;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOT  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_SHR  = 4'd7;
    localparam logic [3:0] ALU_PASS = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_CMP  = 4'd10;

    localparam logic [1:0] FWD_OF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_DM  = 2'd2;
    localparam logic [1:0] FWD_ALT = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} ex_state_t;

    typedef struct packed {
        logic [DW-1:0]   ans;
        logic [DW-1:0]   b_bypass;
        logic [RW_W-1:0] rw;
        logic            mem_en;
        logic            mem_rw;
        logic            mem_mux_sel;
        logic            zero;
        logic            carry;
    } ex_out_t;

    function automatic logic [DW-1:0] fwd_mux(input logic [1:0] sel, input logic [DW-1:0] src,
                                              input logic [DW-1:0] ex, input logic [DW-1:0] dm);
        return (sel == FWD_OF || sel == FWD_ALT) ? src : sel == FWD_EX ? ex : dm;
    endfunction
endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative 8x8 shift-add multiplier, one partial product per cycle.
module seq_multiplier
    import exec_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] product
);
    localparam int CW = $clog2(MUL_CYC);
    localparam logic [CW-1:0] LAST = CW'(MUL_CYC - 1);

    logic [2*DW-1:0] mcand;
    logic [DW-1:0]   mplier;
    logic [CW-1:0]   cnt;

    // High during the cycle whose edge adds the final partial product.
    assign done = busy && cnt == LAST;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= '0;
            mcand   <= {{DW{1'b0}}, a};
            mplier  <= b;
            product <= '0;
        end else if (busy) begin
            product <= mplier[0] ? product + mcand : product;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt + 1'b1;
            busy    <= !done;
        end
    end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: forwarding muxes, single-cycle ALU and pipeline registers feeding
// the data-memory stage; MUL runs on seq_multiplier while upstream is stalled.
module execute_stage
    import exec_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_of,
    input  logic [DW-1:0]   A_of,
    input  logic [DW-1:0]   B_of,
    input  logic [DW-1:0]   imm_of,
    input  logic            imm_sel_of,
    input  logic [3:0]      alu_op_of,
    input  logic [1:0]      fwd_a_sel,
    input  logic [1:0]      fwd_b_sel,
    input  logic [DW-1:0]   mux_ans_dm,
    input  logic [RW_W-1:0] RW_of,
    input  logic            mem_en_of,
    input  logic            mem_rw_of,
    input  logic            mem_mux_sel_of,
    output logic [DW-1:0]   ans_ex,
    output logic [DW-1:0]   B_Bypass,
    output logic [RW_W-1:0] RW_ex,
    output logic            mem_en_ex,
    output logic            mem_rw_ex,
    output logic            mem_mux_sel_ex,
    output logic            zero_ex,
    output logic            carry_ex,
    output logic            stall_ex
);
    ex_state_t       state, state_nx;
    ex_out_t         q, d, fetched, mul_ctl;
    logic [DW-1:0]   op_a, op_b, fwd_b, alu_ans;
    logic [DW:0]     sum, diff;
    logic            alu_carry, alu_zero, mul_start, mul_busy, mul_done;
    logic [2*DW-1:0] product;

    assign op_a = fwd_mux(fwd_a_sel, A_of, q.ans, mux_ans_dm);
    assign fwd_b = fwd_mux(fwd_b_sel, B_of, q.ans, mux_ans_dm);
    assign op_b = imm_sel_of ? imm_of : fwd_b;
    assign sum = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};
    assign mul_start = state == ST_IDLE && valid_of && alu_op_of == ALU_MUL;
    assign stall_ex = reset && (mul_start || mul_busy);

    seq_multiplier u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (op_a),
        .b      (op_b),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(product)
    );

    always_comb begin
        alu_carry = 1'b0;
        alu_ans = op_b;
        case (alu_op_of)
            ALU_ADD:  {alu_carry, alu_ans} = sum;
            ALU_SUB:  {alu_carry, alu_ans} = diff;
            ALU_AND:  alu_ans = op_a & op_b;
            ALU_OR:   alu_ans = op_a | op_b;
            ALU_XOR:  alu_ans = op_a ^ op_b;
            ALU_NOT:  alu_ans = ~op_a;
            ALU_SHL:  {alu_carry, alu_ans} = {op_a, 1'b0};
            ALU_SHR:  {alu_ans, alu_carry} = {1'b0, op_a};
            ALU_PASS: alu_ans = op_b;
            ALU_CMP: begin
                alu_ans = op_a;
                alu_carry = diff[DW];
            end
            default: alu_ans = op_b;
        endcase
    end

    // CMP reports the flags of A-B while passing A through.
    assign alu_zero = alu_op_of == ALU_CMP ? diff[DW-1:0] == '0 : alu_ans == '0;
    assign fetched = '{ans: alu_ans, b_bypass: fwd_b, rw: RW_of, mem_en: mem_en_of,
                       mem_rw: mem_rw_of, mem_mux_sel: mem_mux_sel_of,
                       zero: alu_zero, carry: alu_carry};

    always_comb begin
        state_nx = state;
        d = '0;
        case (state)
            ST_IDLE: begin
                if (mul_start) state_nx = ST_MUL;
                else if (valid_of) d = fetched;
            end
            ST_MUL: if (mul_done) state_nx = ST_DONE;
            ST_DONE: begin
                state_nx = ST_IDLE;
                d = mul_ctl;
                d.ans = product[DW-1:0];
                d.zero = product[DW-1:0] == '0;
                d.carry = |product[2*DW-1:DW];
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            q       <= '0;
            mul_ctl <= '0;
        end else begin
            state <= state_nx;
            q     <= d;
            if (mul_start) mul_ctl <= fetched;
        end
    end

    assign ans_ex = q.ans;
    assign B_Bypass = q.b_bypass;
    assign RW_ex = q.rw;
    assign mem_en_ex = q.mem_en;
    assign mem_rw_ex = q.mem_rw;
    assign mem_mux_sel_ex = q.mem_mux_sel;
    assign zero_ex = q.zero;
    assign carry_ex = q.carry;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: randomized and directed stimulus checked every cycle against
// a per-edge schedule of expected outputs built from the ALU/MUL rules.
module tb_execute_stage;
    logic       clk = 1'b0, reset = 1'b0, valid_of = 1'b0, imm_sel_of = 1'b0;
    logic       mem_en_of = 1'b0, mem_rw_of = 1'b0, mem_mux_sel_of = 1'b0;
    logic [7:0] A_of = '0, B_of = '0, imm_of = '0, mux_ans_dm = '0;
    logic [3:0] alu_op_of = '0;
    logic [1:0] fwd_a_sel = '0, fwd_b_sel = '0;
    logic [4:0] RW_of = '0;
    logic [7:0] ans_ex, B_Bypass;
    logic [4:0] RW_ex;
    logic       mem_en_ex, mem_rw_ex, mem_mux_sel_ex, zero_ex, carry_ex, stall_ex;

    execute_stage dut (
        .clk(clk), .reset(reset), .valid_of(valid_of), .A_of(A_of), .B_of(B_of),
        .imm_of(imm_of), .imm_sel_of(imm_sel_of), .alu_op_of(alu_op_of),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mux_ans_dm(mux_ans_dm),
        .RW_of(RW_of), .mem_en_of(mem_en_of), .mem_rw_of(mem_rw_of),
        .mem_mux_sel_of(mem_mux_sel_of), .ans_ex(ans_ex), .B_Bypass(B_Bypass),
        .RW_ex(RW_ex), .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex),
        .mem_mux_sel_ex(mem_mux_sel_ex), .zero_ex(zero_ex), .carry_ex(carry_ex),
        .stall_ex(stall_ex)
    );

    always #5 clk = ~clk;

    typedef struct { int v, op, a, b, imm, dm, fa, fb, isel, rw, en, wr, mux; } ins_t;
    typedef struct { int s, bbv, ans, bb, rw, en, wr, mux, z, c; } ent_t;

    ent_t sched[$];
    ent_t cur = '{default: 0};
    int   tests = 0, fails = 0;
    bit   checking = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input int op, input int a, input int b);
        ins_t i;
        i = '{default: 0};
        i.v = 1;
        i.op = op;
        i.a = a;
        i.b = b;
        return i;
    endfunction

    // Result the stage must register for one instruction, given the ans_ex visible at issue.
    function automatic ent_t model(input ins_t i, input int ex_ans);
        ent_t e;
        int a, fb, b, r;
        e = '{default: 0};
        if (i.v == 0) return e;
        a = i.fa == 1 ? ex_ans : i.fa == 2 ? i.dm : i.a;
        fb = i.fb == 1 ? ex_ans : i.fb == 2 ? i.dm : i.b;
        b = i.isel != 0 ? i.imm : fb;
        case (i.op)
            0: begin r = a + b; e.c = int'(r > 255); end
            1: begin r = a - b; e.c = int'(a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin r = a * 2; e.c = int'(a >= 128); end
            7: begin r = a / 2; e.c = a % 2; end
            9: begin r = a * b; e.c = int'(r > 255); end
            10: begin r = a; e.c = int'(a < b); end
            default: r = b;
        endcase
        e.ans = r & 255;
        e.z = i.op == 10 ? int'(a == b) : int'(e.ans == 0);
        e.bb = fb;
        e.bbv = int'(i.v != 0 && i.op != 9);
        e.rw = i.rw;
        e.en = i.en;
        e.wr = i.wr;
        e.mux = i.mux;
        return e;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur = '{default: 0};
            sched.delete();
        end else if (sched.size() > 0) cur = sched.pop_front();
    end

    always @(negedge clk) begin
        if (reset && checking) begin
            if (sched.size() > 0) chk("stall", int'(stall_ex), sched[0].s);
            chk("ans", int'(ans_ex), cur.ans);
            chk("rw", int'(RW_ex), cur.rw);
            chk("mem_en", int'(mem_en_ex), cur.en);
            chk("mem_rw", int'(mem_rw_ex), cur.wr);
            chk("mem_mux", int'(mem_mux_sel_ex), cur.mux);
            chk("zero", int'(zero_ex), cur.z);
            chk("carry", int'(carry_ex), cur.c);
            if (cur.bbv != 0) chk("b_bypass", int'(B_Bypass), cur.bb);
        end
    end

    task automatic apply(input ins_t i, output int n);
        ent_t e, bub;
        e = model(i, cur.ans);
        bub = '{default: 0};
        bub.s = 1;
        valid_of = i.v != 0;
        alu_op_of = 4'(i.op);
        A_of = 8'(i.a);
        B_of = 8'(i.b);
        imm_of = 8'(i.imm);
        mux_ans_dm = 8'(i.dm);
        fwd_a_sel = 2'(i.fa);
        fwd_b_sel = 2'(i.fb);
        imm_sel_of = i.isel != 0;
        RW_of = 5'(i.rw);
        mem_en_of = i.en != 0;
        mem_rw_of = i.wr != 0;
        mem_mux_sel_of = i.mux != 0;
        n = (i.v != 0 && i.op == 9) ? 10 : 1;
        if (n == 10) repeat (9) sched.push_back(bub);
        sched.push_back(e);
    endtask

    task automatic issue(input ins_t i, output int ns);
        int n;
        apply(i, n);
        ns = 0;
        repeat (n) begin
            @(negedge clk);
            if (stall_ex) ns++;
            @(posedge clk);
        end
        #2;
    endtask

    task automatic idle(input int cycles);
        ins_t i;
        int ns;
        i = '{default: 0};
        repeat (cycles) issue(i, ns);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_ans", int'(ans_ex), 0);
        chk("rst_rw", int'(RW_ex), 0);
        chk("rst_flags", int'({zero_ex, carry_ex}), 0);
        chk("rst_mem", int'({mem_en_ex, mem_rw_ex, mem_mux_sel_ex}), 0);
        chk("rst_bb", int'(B_Bypass), 0);
        chk("rst_stall", int'(stall_ex), 0);
        valid_of = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        ins_t i;
        ent_t e;
        int ns;
        e = model(mk(0, 'hF0, 'h20), 0);
        chk("pin_add", e.ans * 2 + e.c, 'h21);
        e = model(mk(9, 'h20, 'h10), 0);
        chk("pin_mul", e.ans * 4 + e.z * 2 + e.c, 3);
        e = model(mk(10, 3, 7), 0);
        chk("pin_cmp", e.ans * 4 + e.z * 2 + e.c, 'hD);
        e = model(mk(7, 'h81, 0), 0);
        chk("pin_shr", e.ans * 2 + e.c, 'h81);

        repeat (2) @(posedge clk);
        chk("init_stall", int'(stall_ex), 0);
        chk("init_ans", int'(ans_ex), 0);
        #2;
        reset = 1'b1;
        checking = 1'b1;

        i = mk(0, 'hF0, 'h20);
        i.rw = 3;
        issue(i, ns);
        chk("add_ans", int'(ans_ex), 'h10);
        chk("add_flags", int'({carry_ex, zero_ex}), 2);
        chk("add_rw", int'(RW_ex), 3);
        do_reset();

        i = mk(0, 'h10, 0);
        i.imm = 4; i.isel = 1; i.fb = 2; i.dm = 'h5A; i.en = 1; i.wr = 1; i.rw = 9;
        issue(i, ns);
        chk("st_ans", int'(ans_ex), 'h14);
        chk("st_bb", int'(B_Bypass), 'h5A);
        chk("st_mem", int'({mem_en_ex, mem_rw_ex}), 3);
        idle(3);
        chk("bub_rw", int'(RW_ex), 0);
        chk("bub_en", int'(mem_en_ex), 0);
        issue(mk(1, 5, 5), ns);
        chk("sub_flags", int'({zero_ex, carry_ex}), 2);

        i = mk(9, 'h0D, 'h0B);
        i.rw = 7; i.en = 1;
        issue(i, ns);
        chk("mul1_stall_cycles", ns, 9);
        chk("mul1_ans", int'(ans_ex), 'h8F);
        chk("mul1_carry", int'(carry_ex), 0);
        chk("mul1_rw", int'(RW_ex), 7);
        issue(mk(9, 'h20, 'h10), ns);
        chk("mul2_stall_cycles", ns, 9);
        chk("mul2_flags", int'({ans_ex, zero_ex, carry_ex}), 3);

        apply(mk(9, 'h0D, 'h0B), ns);
        repeat (4) @(posedge clk);
        #2;
        do_reset();
        idle(12);
        chk("abort_no_result", int'(ans_ex), 0);
        issue(mk(0, 1, 2), ns);
        chk("post_abort_add", int'(ans_ex), 3);

        repeat (250) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else begin
                i.v = 1;
                i.op = $urandom_range(0, 15);
                i.a = $urandom_range(0, 255);
                i.b = $urandom_range(0, 255);
                i.imm = $urandom_range(0, 255);
                i.dm = $urandom_range(0, 255);
                i.fa = $urandom_range(0, 3);
                i.fb = $urandom_range(0, 3);
                i.isel = $urandom_range(0, 1);
                i.rw = $urandom_range(0, 31);
                i.en = $urandom_range(0, 1);
                i.wr = $urandom_range(0, 1);
                i.mux = $urandom_range(0, 1);
                issue(i, ns);
                if (i.op == 9) chk("rand_mul_stall_cycles", ns, 9);
            end
        end
        idle(2);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
